// File: rtl/serial_dma_writer.sv
// Packs an incoming byte stream into 32-bit words and writes them to memory
// through a single-cycle write strobe, starting at a latched base address.
module serial_dma_writer #(
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int LEN_W      = 6
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             i_Start,
  input  logic [15:0]      i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0]      i_RCC_DMA_ADDR_LOW,
  input  logic [LEN_W-1:0] i_RCC_BUFFER_LENGTH,
  input  logic [7:0]       i_serialized_input,
  input  logic             i_serialized_input_valid,
  output logic             o_ready,
  output logic [31:0]      mem_WR_addr,
  output logic             mem_write_flag,
  output logic [31:0]      HWDATA_toMem,
  output logic [1:0]       o_Deserialize_Counter,
  output logic [15:0]      o_Bytes_Counter,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Overrun
);

  // Byte handshake: a byte transfers on a rising edge where
  // i_serialized_input_valid and o_ready are both high; there is no back-pressure
  // on the memory side, the write strobe is always taken in its own cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_idx;
  logic [1:0]       r_slot;
  logic [15:0]      r_bytes;
  logic [31:0]      r_asm;
  logic             r_last_acc;
  logic             r_wr_flag;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_overrun;

  logic             w_ready;
  logic             w_accept;
  logic             w_start;
  logic [1:0]       w_pos;
  logic [31:0]      w_asm_next;
  logic [31:0]      w_word_addr;
  logic [LEN_W-1:0] w_word_idx_inc;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_Start) w_next_state = (i_RCC_BUFFER_LENGTH == '0) ? S_DONE : S_ACTIVE;
      S_ACTIVE: if (r_wr_flag && r_last_acc) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Ready drops as soon as the final byte is taken, so it is already low
  // during the last word's write strobe.
  always_comb begin
    w_ready = (r_state == S_ACTIVE) && !r_last_acc;
    o_Busy  = (r_state != S_IDLE);
    o_Done  = (r_state == S_DONE);
  end

  assign w_start        = (r_state == S_IDLE) && i_Start;
  assign w_accept       = i_serialized_input_valid && w_ready;
  assign w_pos          = BIG_ENDIAN ? 2'(2'd3 - r_slot) : r_slot;
  assign w_word_addr    = r_base + {{(30-LEN_W){1'b0}}, r_word_idx, 2'b00};
  assign w_word_idx_inc = r_word_idx + 1'b1;

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[w_pos*8 +: 8] = i_serialized_input;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_base     <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_slot     <= '0;
      r_bytes    <= '0;
      r_asm      <= '0;
      r_last_acc <= 1'b0;
      r_wr_flag  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_wr_flag <= 1'b0;
      if (w_start) begin
        r_base     <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW} & 32'hFFFF_FFFC;
        r_len      <= i_RCC_BUFFER_LENGTH;
        r_word_idx <= '0;
        r_slot     <= '0;
        r_bytes    <= '0;
        r_last_acc <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        if (i_serialized_input_valid && !w_ready) r_overrun <= 1'b1;
        if (w_accept) begin
          r_asm   <= w_asm_next;
          r_slot  <= r_slot + 2'd1;
          r_bytes <= r_bytes + 16'd1;
          if (r_slot == 2'd3) begin
            r_wr_flag  <= 1'b1;
            r_wr_data  <= w_asm_next;
            r_wr_addr  <= w_word_addr;
            r_word_idx <= w_word_idx_inc;
            if (w_word_idx_inc == r_len) r_last_acc <= 1'b1;
          end
        end
      end
    end
  end

  assign o_ready               = w_ready;
  assign mem_WR_addr           = r_wr_addr;
  assign mem_write_flag        = r_wr_flag;
  assign HWDATA_toMem          = r_wr_data;
  assign o_Deserialize_Counter = r_slot;
  assign o_Bytes_Counter       = r_bytes;
  assign o_Overrun             = r_overrun;

endmodule

// File: tb/tb_serial_dma_writer.sv
// Directed bench for serial_dma_writer: one little-endian and one big-endian
// instance share the byte stream; each has its own start and write scoreboard.
module tb_serial_dma_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_le = 1'b0;
  logic        start_be = 1'b0;
  logic [15:0] addr_hi = '0;
  logic [15:0] addr_lo = '0;
  logic [5:0]  len = '0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;

  logic        le_ready, le_flag, le_busy, le_done, le_ovr;
  logic [31:0] le_addr, le_data;
  logic [1:0]  le_slot;
  logic [15:0] le_bytes;
  logic        be_ready, be_flag, be_busy, be_done, be_ovr;
  logic [31:0] be_addr, be_data;
  logic [1:0]  be_slot;
  logic [15:0] be_bytes;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] exp_le_q[$];
  logic [63:0] exp_be_q[$];

  always #5 clk = ~clk;

  serial_dma_writer #(.BIG_ENDIAN(1'b0), .LEN_W(6)) dut_le (
    .HCLK(clk), .HRESETn(rst_n), .i_Start(start_le),
    .i_RCC_DMA_ADDR_HIGH(addr_hi), .i_RCC_DMA_ADDR_LOW(addr_lo),
    .i_RCC_BUFFER_LENGTH(len), .i_serialized_input(din),
    .i_serialized_input_valid(din_valid), .o_ready(le_ready),
    .mem_WR_addr(le_addr), .mem_write_flag(le_flag), .HWDATA_toMem(le_data),
    .o_Deserialize_Counter(le_slot), .o_Bytes_Counter(le_bytes),
    .o_Busy(le_busy), .o_Done(le_done), .o_Overrun(le_ovr));

  serial_dma_writer #(.BIG_ENDIAN(1'b1), .LEN_W(6)) dut_be (
    .HCLK(clk), .HRESETn(rst_n), .i_Start(start_be),
    .i_RCC_DMA_ADDR_HIGH(addr_hi), .i_RCC_DMA_ADDR_LOW(addr_lo),
    .i_RCC_BUFFER_LENGTH(len), .i_serialized_input(din),
    .i_serialized_input_valid(din_valid), .o_ready(be_ready),
    .mem_WR_addr(be_addr), .mem_write_flag(be_flag), .HWDATA_toMem(be_data),
    .o_Deserialize_Counter(be_slot), .o_Bytes_Counter(be_bytes),
    .o_Busy(be_busy), .o_Done(be_done), .o_Overrun(be_ovr));

  // Monitor: every write strobe must match the head of its instance's queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (le_flag) begin
      compared++;
      if (exp_le_q.size() == 0) begin
        mismatched++;
        $display("FAIL le_write: unexpected write addr=%h data=%h", le_addr, le_data);
      end else begin
        e = exp_le_q.pop_front();
        if ({le_addr, le_data} !== e) begin
          mismatched++;
          $display("FAIL le_write: got addr=%h data=%h, want addr=%h data=%h",
                   le_addr, le_data, e[63:32], e[31:0]);
        end
      end
    end
    if (be_flag) begin
      compared++;
      if (exp_be_q.size() == 0) begin
        mismatched++;
        $display("FAIL be_write: unexpected write addr=%h data=%h", be_addr, be_data);
      end else begin
        e = exp_be_q.pop_front();
        if ({be_addr, be_data} !== e) begin
          mismatched++;
          $display("FAIL be_write: got addr=%h data=%h, want addr=%h data=%h",
                   be_addr, be_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input bit be, input logic [15:0] hi, input logic [15:0] lo,
                          input logic [5:0] l);
    addr_hi = hi; addr_lo = lo; len = l;
    if (be) start_be = 1'b1; else start_le = 1'b1;
    tick();
    start_be = 1'b0; start_le = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din = b; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] t1_bytes[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] t2_bytes[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_le_outputs", {le_ready, le_flag, le_busy, le_done, le_ovr, le_slot, le_bytes}, 32'h0);
    chk("reset_le_addr", le_addr, 32'h0);
    chk("reset_be_outputs", {be_ready, be_flag, be_busy, be_done, be_ovr, be_slot, be_bytes}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // T1: little-endian, two words back to back
    exp_le_q.push_back({32'h0001_0100, 32'h4433_2211});
    exp_le_q.push_back({32'h0001_0104, 32'h8877_6655});
    do_start(1'b0, 16'h0001, 16'h0100, 6'd2);
    @(negedge clk);
    chk("t1_ready_active", le_ready, 1);
    tick();
    for (int i = 0; i < 8; i++) send_byte(t1_bytes[i]);
    @(negedge clk);
    chk("t1_strobe", le_flag, 1);
    chk("t1_ready_low_on_last_strobe", le_ready, 0);
    chk("t1_done_not_yet", le_done, 0);
    tick(); @(negedge clk);
    chk("t1_done_pulse", le_done, 1);
    chk("t1_bytes", le_bytes, 8);
    tick(); @(negedge clk);
    chk("t1_done_cleared", {le_done, le_busy}, 0);

    // T2: big-endian with idle gaps
    exp_be_q.push_back({32'h0000_0200, 32'hAABB_CCDD});
    do_start(1'b1, 16'h0000, 16'h0200, 6'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(t2_bytes[i]);
      if (i < 3) begin
        @(negedge clk);
        chk("t2_no_early_strobe", be_flag, 0);
        repeat (3) tick();
      end
    end
    @(negedge clk);
    chk("t2_strobe_one_after_last", be_flag, 1);
    repeat (3) tick();

    // T3: zero length
    do_start(1'b0, 16'h0000, 16'h0400, 6'd0);
    @(negedge clk);
    chk("t3_done_busy", {le_done, le_busy}, 2'b11);
    tick(); @(negedge clk);
    chk("t3_idle_again", {le_done, le_busy}, 2'b00);
    tick();

    // T4: address wrap, low bits of base forced to zero
    exp_le_q.push_back({32'hFFFF_FFFC, 32'h0403_0201});
    exp_le_q.push_back({32'h0000_0000, 32'h0807_0605});
    do_start(1'b0, 16'hFFFF, 16'hFFFF, 6'd2);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (3) tick();

    // T5: overrun after the last word
    exp_le_q.push_back({32'h0000_2000, 32'h4030_2010});
    do_start(1'b0, 16'h0000, 16'h2000, 6'd1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 16));
    @(negedge clk);
    chk("t5_overrun_set", le_ovr, 1);
    chk("t5_bytes_counter", le_bytes, 4);
    repeat (2) tick();
    @(negedge clk);
    chk("t5_overrun_sticky", le_ovr, 1);
    do_start(1'b0, 16'h0000, 16'h2000, 6'd0);
    @(negedge clk);
    chk("t5_overrun_cleared", le_ovr, 0);
    repeat (2) tick();

    // T6: reset mid-transfer, then restart at the base
    exp_le_q.push_back({32'h0000_3000, 32'h0403_0201});
    do_start(1'b0, 16'h0000, 16'h3000, 6'd4);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    @(negedge clk);
    chk("t6_slot_before_reset", le_slot, 2);
    chk("t6_bytes_before_reset", le_bytes, 6);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("t6_reset_outputs", {le_ready, le_flag, le_busy, le_done, le_ovr, le_slot, le_bytes}, 32'h0);
    chk("t6_reset_data", le_data, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_le_q.push_back({32'h0000_3000, 32'hA4A3_A2A1});
    do_start(1'b0, 16'h0000, 16'h3000, 6'd1);
    for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i));
    repeat (4) tick();

    @(negedge clk);
    chk("le_queue_drained", exp_le_q.size(), 0);
    chk("be_queue_drained", exp_be_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
